// File: rtl/pipe_mem.sv
// MEM stage: EX/MEM latch (R), IDLE/BUSY data-memory handshake, MEM/WB latch (W).
// Handles byte/half/word lanes, drops misaligned accesses and aborts after WAIT_LIMIT busy cycles.
module pipe_mem #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_valid,
    input  logic        in_flush,
    input  logic        in_dmem_ena,
    input  logic        in_dmem_wena,
    input  logic [1:0]  in_dmem_type,
    input  logic        in_dmem_sext,
    input  logic [31:0] in_rt_data,
    input  logic [4:0]  in_rd_waddr,
    input  logic        in_rd_sel,
    input  logic        in_rd_wena,
    input  logic [31:0] in_alu_result,
    output logic        out_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd_waddr,
    output logic        out_rd_sel,
    output logic        out_rd_wena,
    output logic [31:0] out_alu_result,
    output logic [31:0] out_load_data,
    output logic        out_misalign,
    output logic        out_bus_err,
    output logic        dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    logic [0:0]  state;
    logic [7:0]  wait_cnt;

    logic        r_valid;
    logic        r_mem;
    logic        r_we;
    logic [1:0]  r_type;
    logic        r_sext;
    logic        r_misalign;
    logic [31:0] r_rt;
    logic [4:0]  r_rd_waddr;
    logic        r_rd_sel;
    logic        r_rd_wena;
    logic [31:0] r_alu;

    function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] a);
        case (typ)
            2'b01:   return a[0];
            2'b10:   return 1'b0;
            default: return a != 2'b00;
        endcase
    endfunction

    logic        in_misalign;
    logic        capture_op;
    logic        start_mem;
    logic        busy;
    logic        timeout;
    logic [1:0]  lane;

    assign in_misalign = in_dmem_ena & is_misaligned(in_dmem_type, in_alu_result[1:0]);
    assign capture_op  = in_valid & ~in_flush;
    assign start_mem   = capture_op & in_dmem_ena & ~in_misalign;
    assign busy        = (state == ST_BUSY);
    assign timeout     = (WAIT_LIMIT != 0) && busy && !mem_ack && (wait_cnt == LIMIT_M1);
    assign out_stall   = busy & ~mem_ack & ~timeout;
    assign lane        = r_alu[1:0];
    assign dbg_state   = state;

    // Bus handshake: mem_req stays high with we/addr/be/wdata held stable until mem_ack;
    // the access completes in the ack cycle (rdata valid with it). Ack while IDLE is ignored.
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = r_rt;
        case (r_type)
            2'b01: begin
                be_c    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{r_rt[15:0]}};
            end
            2'b10: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{r_rt[7:0]}};
            end
            default: ;
        endcase
    end

    assign mem_req   = busy;
    assign mem_we    = busy & r_we;
    assign mem_addr  = busy ? {r_alu[31:2], 2'b00} : 32'h0;
    assign mem_be    = busy ? be_c : 4'b0000;
    assign mem_wdata = busy ? wdata_c : 32'h0;

    logic [15:0] half_c;
    logic [7:0]  byte_c;
    logic [31:0] load_c;

    always_comb begin
        half_c = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lane)
            2'b00:   byte_c = mem_rdata[7:0];
            2'b01:   byte_c = mem_rdata[15:8];
            2'b10:   byte_c = mem_rdata[23:16];
            default: byte_c = mem_rdata[31:24];
        endcase
        case (r_type)
            2'b01:   load_c = r_sext ? {{16{half_c[15]}}, half_c} : {16'h0, half_c};
            2'b10:   load_c = r_sext ? {{24{byte_c[7]}}, byte_c} : {24'h0, byte_c};
            default: load_c = mem_rdata;
        endcase
    end

    logic r_store;
    logic r_load_ok;

    assign r_store   = r_mem & r_we;
    assign r_load_ok = r_mem & ~r_we & ~r_misalign & busy & mem_ack;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'h0;
        end else begin
            wait_cnt <= out_stall ? wait_cnt + 8'h1 : 8'h0;
            if (!out_stall) begin
                state <= start_mem ? ST_BUSY : ST_IDLE;
            end
        end
    end

    // R only moves when the stage is free; flush is meaningless while an access is held.
    always_ff @(posedge in_clk) begin
        if (in_rst || (!out_stall && !capture_op)) begin
            r_valid    <= 1'b0;
            r_mem      <= 1'b0;
            r_we       <= 1'b0;
            r_type     <= 2'b00;
            r_sext     <= 1'b0;
            r_misalign <= 1'b0;
            r_rt       <= 32'h0;
            r_rd_waddr <= 5'h0;
            r_rd_sel   <= 1'b0;
            r_rd_wena  <= 1'b0;
            r_alu      <= 32'h0;
        end else if (!out_stall) begin
            r_valid    <= 1'b1;
            r_mem      <= in_dmem_ena;
            r_we       <= in_dmem_wena;
            r_type     <= in_dmem_type;
            r_sext     <= in_dmem_sext;
            r_misalign <= in_misalign;
            r_rt       <= in_rt_data;
            r_rd_waddr <= in_rd_waddr;
            r_rd_sel   <= in_rd_sel;
            r_rd_wena  <= in_rd_wena;
            r_alu      <= in_alu_result;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst || out_stall) begin
            out_valid      <= 1'b0;
            out_rd_waddr   <= 5'h0;
            out_rd_sel     <= 1'b0;
            out_rd_wena    <= 1'b0;
            out_alu_result <= 32'h0;
            out_load_data  <= 32'h0;
            out_misalign   <= 1'b0;
            out_bus_err    <= 1'b0;
        end else begin
            out_valid      <= r_valid;
            out_rd_waddr   <= r_rd_waddr;
            out_rd_sel     <= r_rd_sel;
            out_rd_wena    <= r_valid & r_rd_wena & ~r_store & ~r_misalign & ~timeout;
            out_alu_result <= r_alu;
            out_load_data  <= r_load_ok ? load_c : 32'h0;
            out_misalign   <= r_valid & r_misalign;
            out_bus_err    <= timeout;
        end
    end

endmodule

// File: tb/tb_pipe_mem.sv
// Bench for pipe_mem: directed scenarios plus a randomized back-to-back run with a bus responder;
// WB results and bus requests are checked against expected queues filled when stimulus is driven.
module tb_pipe_mem;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_valid;
    logic        in_flush;
    logic        in_dmem_ena;
    logic        in_dmem_wena;
    logic [1:0]  in_dmem_type;
    logic        in_dmem_sext;
    logic [31:0] in_rt_data;
    logic [4:0]  in_rd_waddr;
    logic        in_rd_sel;
    logic        in_rd_wena;
    logic [31:0] in_alu_result;
    logic        out_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd_waddr;
    logic        out_rd_sel;
    logic        out_rd_wena;
    logic [31:0] out_alu_result;
    logic [31:0] out_load_data;
    logic        out_misalign;
    logic        out_bus_err;
    logic        dbg_state;

    pipe_mem #(.WAIT_LIMIT(4)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .in_flush(in_flush),
        .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena), .in_dmem_type(in_dmem_type),
        .in_dmem_sext(in_dmem_sext), .in_rt_data(in_rt_data), .in_rd_waddr(in_rd_waddr),
        .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena), .in_alu_result(in_alu_result),
        .out_stall(out_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rd_waddr(out_rd_waddr), .out_rd_sel(out_rd_sel),
        .out_rd_wena(out_rd_wena), .out_alu_result(out_alu_result),
        .out_load_data(out_load_data), .out_misalign(out_misalign),
        .out_bus_err(out_bus_err), .dbg_state(dbg_state)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    // {rd_waddr, rd_sel, rd_wena, alu_result, load_data, misalign, bus_err}
    logic [72:0] exp_q[$];
    // {we, addr, be, wdata (stores only)}
    logic [68:0] bus_q[$];
    logic [72:0] got_wb, exp_wb;
    logic [68:0] got_bus, exp_bus;
    bit          auto_ack = 1'b0;
    bit          in_access = 1'b0;
    int          wait_left = 0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rdata_of(input logic [31:0] waddr);
        return (waddr * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic model_misalign(input logic [1:0] typ, input logic [1:0] a);
        if (typ == 2'b10) return 1'b0;
        if (typ == 2'b01) return a[0] == 1'b1;
        return a != 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] typ, input logic [1:0] a);
        if (typ == 2'b01) return (a[1] == 1'b1) ? 4'b1100 : 4'b0011;
        if (typ == 2'b10) begin
            case (a)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] typ, input logic [31:0] rt);
        if (typ == 2'b01) return {rt[15:0], rt[15:0]};
        if (typ == 2'b10) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
        return rt;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] typ, input logic [1:0] a,
                                               input logic sext, input logic [31:0] rd);
        logic [31:0] sh;
        logic [15:0] h;
        logic [7:0]  b;
        sh = rd >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? rd[31:16] : rd[15:0];
        if (typ == 2'b01) return sext ? {{16{h[15]}}, h} : {16'h0, h};
        if (typ == 2'b10) return sext ? {{24{b[7]}}, b} : {24'h0, b};
        return rd;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic clear_ex();
        in_valid = 0; in_flush = 0; in_dmem_ena = 0; in_dmem_wena = 0; in_dmem_type = 2'b00;
        in_dmem_sext = 0; in_rt_data = 32'h0; in_rd_waddr = 5'h0; in_rd_sel = 0;
        in_rd_wena = 0; in_alu_result = 32'h0;
    endtask

    // Presents one EX op, waits until R captures it, returns one time unit after that edge.
    task automatic drive_op(input logic v, input logic fl, input logic ena, input logic we,
                            input logic [1:0] typ, input logic sext, input logic [31:0] rt,
                            input logic [4:0] rd, input logic sel, input logic rdw,
                            input logic [31:0] addr, input logic [31:0] rdata, input logic berr);
        logic s, captured, mis, store;
        logic [31:0] ld;
        in_valid = v; in_flush = fl; in_dmem_ena = ena; in_dmem_wena = we; in_dmem_type = typ;
        in_dmem_sext = sext; in_rt_data = rt; in_rd_waddr = rd; in_rd_sel = sel;
        in_rd_wena = rdw; in_alu_result = addr;
        captured = 0;
        for (int i = 0; i < 50 && !captured; i++) begin
            @(negedge in_clk);
            s = out_stall;
            step();
            if (!s) captured = 1;
        end
        clear_ex();
        checks++;
        if (captured !== 1'b1) begin
            errors++;
            $display("FAIL capture_timeout got=%0b exp=1 addr=%h", captured, addr);
        end
        if (v && !fl) begin
            mis   = ena && model_misalign(typ, addr[1:0]);
            store = ena && we;
            ld    = (ena && !we && !mis && !berr) ? model_load(typ, addr[1:0], sext, rdata) : 32'h0;
            exp_q.push_back({rd, sel, rdw && !store && !mis && !berr, addr, ld, mis, berr});
            if (ena && !mis && auto_ack)
                bus_q.push_back({we, addr[31:2], 2'b00, model_be(typ, addr[1:0]),
                                 we ? model_wdata(typ, rt) : 32'h0});
        end
    endtask

    // ---------------- WB scoreboard ----------------
    always @(negedge in_clk) begin
        if (!in_rst && out_valid) begin
            got_wb = {out_rd_waddr, out_rd_sel, out_rd_wena, out_alu_result, out_load_data,
                      out_misalign, out_bus_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got=%h exp=none", got_wb);
            end else begin
                exp_wb = exp_q.pop_front();
                if (got_wb !== exp_wb) begin
                    errors++;
                    $display("FAIL wb_result got=%h exp=%h", got_wb, exp_wb);
                end
            end
        end
    end

    // ---------------- bus responder (random ack delay, bus request check) ----------------
    always @(posedge in_clk) begin
        #2;
        if (!auto_ack) begin
            in_access = 0;
        end else begin
            if (mem_ack) begin
                mem_ack = 0;
                in_access = 0;
            end
            if (mem_req) begin
                if (!in_access) begin
                    in_access = 1;
                    wait_left = $urandom_range(0, 2);
                    got_bus = {mem_we, mem_addr, mem_be, mem_we ? mem_wdata : 32'h0};
                    checks++;
                    if (bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_unexpected got=%h exp=none", got_bus);
                    end else begin
                        exp_bus = bus_q.pop_front();
                        if (got_bus !== exp_bus) begin
                            errors++;
                            $display("FAIL bus_request got=%h exp=%h", got_bus, exp_bus);
                        end
                    end
                end
                if (wait_left == 0) begin
                    mem_ack = 1;
                    mem_rdata = rdata_of(mem_addr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_rst = 1; mem_ack = 0; mem_rdata = 32'h0;
        clear_ex();
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", out_stall); end
        checks++; if ({mem_addr, mem_be} !== 36'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {mem_addr, mem_be}); end
        checks++; if ({out_load_data, out_rd_wena, out_bus_err} !== 34'h0) begin errors++; $display("FAIL reset_wb got=%h exp=0", {out_load_data, out_rd_wena, out_bus_err}); end
        checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
        in_rst = 0;
        step();
    endtask

    task automatic test_alu_op();
        drive_op(1, 0, 0, 0, 2'b00, 0, 32'h0, 5'd5, 0, 1, 32'h40, 32'h0, 0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req got=%0b exp=0", mem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_early got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h40) begin errors++; $display("FAIL alu_result got=%0b/%h exp=1/00000040", out_valid, out_alu_result); end
        checks++; if (out_rd_wena !== 1'b1 || out_rd_waddr !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0b/%0d exp=1/5", out_rd_wena, out_rd_waddr); end
    endtask

    task automatic test_load_byte();
        int stall_cycles = 0;
        drive_op(1, 0, 1, 0, 2'b10, 1, 32'h0, 5'd7, 1, 1, 32'h103, 32'h80123456, 0);
        checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1000, 32'h100}) begin errors++; $display("FAIL lb_bus got=%0b%0b/%b/%h exp=10/1000/00000100", mem_req, mem_we, mem_be, mem_addr); end
        for (int i = 0; i < 3; i++) begin
            if (out_stall) stall_cycles++;
            step();
        end
        mem_ack = 1; mem_rdata = 32'h80123456;
        #1;
        checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL lb_stall_on_ack got=%0b exp=0", out_stall); end
        checks++; if (stall_cycles !== 3) begin errors++; $display("FAIL lb_stall_cycles got=%0d exp=3", stall_cycles); end
        step();
        mem_ack = 0;
        checks++; if (out_valid !== 1'b1 || out_load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%0b/%h exp=1/ffffff80", out_valid, out_load_data); end
    endtask

    task automatic test_store();
        drive_op(1, 0, 1, 1, 2'b01, 0, 32'h1234ABCD, 5'd9, 0, 1, 32'h202, 32'h0, 0);
        checks++; if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h200}) begin errors++; $display("FAIL sh_bus got=%0b/%b/%h/%h exp=1/1100/abcdabcd/00000200", mem_we, mem_be, mem_wdata, mem_addr); end
        mem_ack = 1; step(); mem_ack = 0;
        checks++; if (out_valid !== 1'b1 || out_rd_wena !== 1'b0) begin errors++; $display("FAIL sh_wena got=%0b/%0b exp=1/0", out_valid, out_rd_wena); end
        drive_op(1, 0, 1, 1, 2'b10, 0, 32'h000000EF, 5'd10, 0, 1, 32'h1, 32'h0, 0);
        checks++; if ({mem_be, mem_wdata} !== {4'b0010, 32'hEFEFEFEF}) begin errors++; $display("FAIL sb_bus got=%b/%h exp=0010/efefefef", mem_be, mem_wdata); end
        mem_ack = 1; step(); mem_ack = 0;
    endtask

    task automatic test_misalign();
        drive_op(1, 0, 1, 0, 2'b00, 0, 32'h0, 5'd3, 0, 1, 32'h6, 32'h0, 0);
        checks++; if ({mem_req, out_stall, dbg_state} !== 3'b000) begin errors++; $display("FAIL lw_mis_req got=%b exp=000", {mem_req, out_stall, dbg_state}); end
        step();
        checks++; if ({out_valid, out_misalign, out_rd_wena} !== 3'b110) begin errors++; $display("FAIL lw_mis_wb got=%b exp=110", {out_valid, out_misalign, out_rd_wena}); end
        drive_op(1, 0, 1, 0, 2'b01, 0, 32'h0, 5'd4, 0, 1, 32'h6, 32'hBEEF1234, 0);
        checks++; if ({mem_req, mem_be} !== {1'b1, 4'b1100}) begin errors++; $display("FAIL lhu_req got=%b exp=11100", {mem_req, mem_be}); end
        mem_ack = 1; mem_rdata = 32'hBEEF1234; step(); mem_ack = 0;
        checks++; if (out_load_data !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got=%h exp=0000beef", out_load_data); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_op(1, 0, 1, 0, 2'b00, 0, 32'h0, 5'd4, 0, 1, 32'h300, 32'h0, 1);
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            req_cycles++;
            if (req_cycles == 4) begin
                checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL timeout_stall got=%0b exp=0", out_stall); end
            end
            step();
        end
        checks++; if (req_cycles !== 4) begin errors++; $display("FAIL timeout_req_cycles got=%0d exp=4", req_cycles); end
        checks++; if ({out_valid, out_bus_err, out_rd_wena} !== 3'b110) begin errors++; $display("FAIL timeout_wb got=%b exp=110", {out_valid, out_bus_err, out_rd_wena}); end
        mem_ack = 1; mem_rdata = 32'h12345678;
        #1;
        checks++; if ({mem_req, out_stall} !== 2'b00) begin errors++; $display("FAIL late_ack_idle got=%b exp=00", {mem_req, out_stall}); end
        step(); mem_ack = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_ack_wb got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush_stalled();
        drive_op(1, 0, 1, 0, 2'b00, 0, 32'h0, 5'd11, 0, 1, 32'h500, 32'hCAFEF00D, 0);
        in_valid = 1; in_flush = 1; in_rd_waddr = 5'd12; in_alu_result = 32'h999;
        step();
        checks++; if ({out_valid, mem_req, mem_addr} !== {2'b01, 32'h500}) begin errors++; $display("FAIL flush_stalled_hold got=%b/%h exp=01/00000500", {out_valid, mem_req}, mem_addr); end
        step();
        clear_ex();
        mem_ack = 1; mem_rdata = 32'hCAFEF00D; step(); mem_ack = 0;
        checks++; if ({out_valid, out_rd_waddr, out_load_data} !== {1'b1, 5'd11, 32'hCAFEF00D}) begin errors++; $display("FAIL flush_stalled_wb got=%0b/%0d/%h exp=1/11/cafef00d", out_valid, out_rd_waddr, out_load_data); end
    endtask

    task automatic test_reset_busy();
        in_valid = 1; in_dmem_ena = 1; in_rd_wena = 1; in_rd_waddr = 5'd13; in_alu_result = 32'h600;
        step();
        clear_ex();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req got=%0b exp=1", mem_req); end
        in_rst = 1; step();
        checks++; if ({mem_req, out_valid, out_stall} !== 3'b000) begin errors++; $display("FAIL rst_busy_drop got=%b exp=000", {mem_req, out_valid, out_stall}); end
        in_rst = 0; step();
        checks++; if ({mem_req, out_valid} !== 2'b00) begin errors++; $display("FAIL rst_busy_after got=%b exp=00", {mem_req, out_valid}); end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [31:0] addr, rt;
        logic [1:0] typ;
        auto_ack = 1;
        for (int n = 0; n < 60; n++) begin
            k    = $urandom_range(0, 9);
            typ  = 2'($urandom_range(0, 3));
            addr = $urandom;
            rt   = $urandom;
            drive_op(k != 0, k == 1, k >= 4, k >= 7, typ, 1'($urandom_range(0, 1)), rt,
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     addr, rdata_of({addr[31:2], 2'b00}), 0);
        end
        repeat (10) step();
        auto_ack = 0;
        mem_ack = 0;
        step();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wb_drain got=%0d exp=0", exp_q.size()); end
        checks++; if (bus_q.size() !== 0) begin errors++; $display("FAIL bus_drain got=%0d exp=0", bus_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store();
        test_misalign();
        test_timeout();
        test_flush_stalled();
        test_reset_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
